// File: rtl/counter_pair_monitor_if.sv
// rtl/counter_pair_monitor_if.sv - sample and status bundle for counter_pair_monitor
//
// Purpose: groups the sampled X/Y stream and the registered status outputs
//          of counter_pair_monitor.
// Signals:
//   in_valid            sample x/y this cycle (master -> slave)
//   x, y       [W]      leader / follower counter values (master -> slave)
//   state      [2]      0 IDLE, 1 TRACK, 2 DIVERGED, 3 FAIL (slave -> master)
//   order_ok            sticky, cleared once y > x is seen
//   eq_ok               sticky, cleared once x != y is seen
//   step_err            sticky, an illegal per-sample step was seen
//   gap, max_gap [W]    last x - y (0 if y > x) and its maximum
//   wrap_cnt   [CW]     saturating count of x decreasing between samples
//   sample_cnt [CW]     saturating count of accepted samples
//   fail_idx   [CW]     index of the sample that first entered FAIL
interface counter_pair_monitor_if #(
  parameter int W  = 400,
  parameter int CW = 16
);
  logic          in_valid;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [1:0]    state;
  logic          order_ok;
  logic          eq_ok;
  logic          step_err;
  logic [W-1:0]  gap;
  logic [W-1:0]  max_gap;
  logic [CW-1:0] wrap_cnt;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] fail_idx;

  modport master (
    output in_valid, x, y,
    input  state, order_ok, eq_ok, step_err, gap, max_gap,
           wrap_cnt, sample_cnt, fail_idx
  );

  modport slave (
    input  in_valid, x, y,
    output state, order_ok, eq_ok, step_err, gap, max_gap,
           wrap_cnt, sample_cnt, fail_idx
  );
endinterface

// File: rtl/counter_pair_monitor.sv
// rtl/counter_pair_monitor.sv - streaming X/Y counter pair checker
//
// Purpose: samples (x, y) pairs from the two-counter generator, tracks the
//          gap x - y and its maximum, checks per-sample step legality and
//          raises sticky registered failure flags. Never back-pressures.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, has priority over in_valid
//   bus   counter_pair_monitor_if.slave: in_valid/x/y in, status out
module counter_pair_monitor #(
  parameter int W  = 400,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  counter_pair_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRACK    = 2'd1,
    S_DIVERGED = 2'd2,
    S_FAIL     = 2'd3
  } state_e;

  localparam logic [W-1:0]  W_ONE  = W'(1);
  localparam logic [CW-1:0] CW_ONE = CW'(1);

  state_e        state_q, state_d;
  logic          order_ok_q, eq_ok_q, step_err_q;
  logic [W-1:0]  gap_q, max_gap_q;
  logic [CW-1:0] wrap_cnt_q, sample_cnt_q, fail_idx_q;
  logic [W-1:0]  px_q, py_q;
  logic          have_prev_q;

  logic          accept;
  logic          y_gt_x;
  logic          x_ne_y;
  logic          x_ok, y_ok;
  logic          step_bad;
  logic          x_wrapped;
  logic          fail_now;
  logic [W-1:0]  gap_new;

  assign accept = bus.in_valid;
  assign y_gt_x = bus.y > bus.x;
  assign x_ne_y = bus.x != bus.y;

  // Each counter may hold, advance by one (mod 2^W) or be copied from the
  // other counter's previous value.
  assign x_ok = (bus.x == px_q) || (bus.x == px_q + W_ONE) || (bus.x == py_q);
  assign y_ok = (bus.y == py_q) || (bus.y == py_q + W_ONE) || (bus.y == px_q);

  // No history on the first sample after reset, so no step can be judged.
  assign step_bad  = have_prev_q && !(x_ok && y_ok);
  assign x_wrapped = have_prev_q && (bus.x < px_q);
  assign fail_now  = y_gt_x || step_bad;
  assign gap_new   = y_gt_x ? '0 : bus.x - bus.y;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. IDLE classifies its first sample like TRACK does, so a
  // diverged first pair lands directly in DIVERGED.
  always_comb begin
    state_d = state_q;
    if (accept && (state_q != S_FAIL)) begin
      if (fail_now) begin
        state_d = S_FAIL;
      end else if (x_ne_y) begin
        state_d = S_DIVERGED;
      end else begin
        state_d = S_TRACK;
      end
    end
  end

  // FSM: outputs, all straight from registers
  always_comb begin
    bus.state      = state_q;
    bus.order_ok   = order_ok_q;
    bus.eq_ok      = eq_ok_q;
    bus.step_err   = step_err_q;
    bus.gap        = gap_q;
    bus.max_gap    = max_gap_q;
    bus.wrap_cnt   = wrap_cnt_q;
    bus.sample_cnt = sample_cnt_q;
    bus.fail_idx   = fail_idx_q;
  end

  // Sample datapath and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      order_ok_q   <= 1'b1;
      eq_ok_q      <= 1'b1;
      step_err_q   <= 1'b0;
      gap_q        <= '0;
      max_gap_q    <= '0;
      wrap_cnt_q   <= '0;
      sample_cnt_q <= '0;
      fail_idx_q   <= '0;
      px_q         <= '0;
      py_q         <= '0;
      have_prev_q  <= 1'b0;
    end else if (accept) begin
      gap_q <= gap_new;
      if (gap_new > max_gap_q) begin
        max_gap_q <= gap_new;
      end
      if (y_gt_x) begin
        order_ok_q <= 1'b0;
      end
      if (x_ne_y) begin
        eq_ok_q <= 1'b0;
      end
      if (step_bad) begin
        step_err_q <= 1'b1;
      end
      if (x_wrapped && (wrap_cnt_q != '1)) begin
        wrap_cnt_q <= wrap_cnt_q + CW_ONE;
      end
      if (sample_cnt_q != '1) begin
        sample_cnt_q <= sample_cnt_q + CW_ONE;
      end
      // Captured only on the transition into FAIL; the pre-increment count
      // is the 0-based index of the offending sample.
      if ((state_q != S_FAIL) && fail_now) begin
        fail_idx_q <= sample_cnt_q;
      end
      px_q        <= bus.x;
      py_q        <= bus.y;
      have_prev_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_pair_monitor.sv
// tb/tb_counter_pair_monitor.sv - scoreboard bench for counter_pair_monitor
module tb_counter_pair_monitor;

  localparam int W       = 3;
  localparam int CW      = 4;
  localparam int M       = 1 << W;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam int IDLE = 0, TRACK = 1, DIVERGED = 2, FAILST = 3;

  typedef struct {
    int    st;
    int    ook;
    int    eok;
    int    serr;
    int    gap;
    int    mgap;
    int    wrap;
    int    cnt;
    int    fidx;
    string tag;
  } exp_t;

  logic clk;
  logic rst;

  counter_pair_monitor_if #(.W(W), .CW(CW)) bus ();

  counter_pair_monitor #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t expq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state, plain integers
  int m_st, m_ook, m_eok, m_serr, m_gap, m_mgap, m_wrap, m_cnt, m_fidx;
  int m_px, m_py, m_hp;

  function automatic void model_reset();
    m_st = IDLE; m_ook = 1; m_eok = 1; m_serr = 0;
    m_gap = 0; m_mgap = 0; m_wrap = 0; m_cnt = 0; m_fidx = 0;
    m_px = 0; m_py = 0; m_hp = 0;
  endfunction

  function automatic void model_sample(int xi, int yi);
    bit se;
    bit fail;
    se = 0;
    if (m_hp != 0) begin
      bit xl, yl;
      xl = (xi == m_px) || (xi == (m_px + 1) % M) || (xi == m_py);
      yl = (yi == m_py) || (yi == (m_py + 1) % M) || (yi == m_px);
      se = !(xl && yl);
      if (xi < m_px && m_wrap < CNT_MAX) m_wrap++;
    end
    m_gap = (xi >= yi) ? xi - yi : 0;
    if (m_gap > m_mgap) m_mgap = m_gap;
    if (yi > xi) m_ook = 0;
    if (xi != yi) m_eok = 0;
    if (se) m_serr = 1;
    fail = (yi > xi) || se;
    if (m_st != FAILST) begin
      if (fail) begin
        m_st   = FAILST;
        m_fidx = m_cnt;
      end else begin
        m_st = (xi != yi) ? DIVERGED : TRACK;
      end
    end
    if (m_cnt < CNT_MAX) m_cnt++;
    m_px = xi; m_py = yi; m_hp = 1;
  endfunction

  function automatic exp_t snap(string tag);
    exp_t e;
    e.st = m_st; e.ook = m_ook; e.eok = m_eok; e.serr = m_serr;
    e.gap = m_gap; e.mgap = m_mgap; e.wrap = m_wrap; e.cnt = m_cnt;
    e.fidx = m_fidx; e.tag = tag;
    return e;
  endfunction

  // One clock of stimulus; the expected post-edge view goes to the scoreboard.
  task automatic drive(bit r, bit v, int xi, int yi, string tag);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.x        = W'(xi % M);
    bus.y        = W'(yi % M);
    if (r) model_reset();
    else if (v) model_sample(xi % M, yi % M);
    expq.push_back(snap(tag));
  endtask

  task automatic sample(int xi, int yi, string tag);
    drive(1'b0, 1'b1, xi, yi, tag);
  endtask

  task automatic do_reset(string tag);
    drive(1'b1, 1'b0, 0, 0, tag);
  endtask

  function automatic void chk(string tag, string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
  endfunction

  // Monitor: outputs are registered, so each pushed expectation is checked
  // just after the edge that consumed its stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk(e.tag, "state",      int'(bus.state),      e.st);
        chk(e.tag, "order_ok",   int'(bus.order_ok),   e.ook);
        chk(e.tag, "eq_ok",      int'(bus.eq_ok),      e.eok);
        chk(e.tag, "step_err",   int'(bus.step_err),   e.serr);
        chk(e.tag, "gap",        int'(bus.gap),        e.gap);
        chk(e.tag, "max_gap",    int'(bus.max_gap),    e.mgap);
        chk(e.tag, "wrap_cnt",   int'(bus.wrap_cnt),   e.wrap);
        chk(e.tag, "sample_cnt", int'(bus.sample_cnt), e.cnt);
        chk(e.tag, "fail_idx",   int'(bus.fail_idx),   e.fidx);
      end
    end
  end

  // Biased choice: mostly legal steps, sometimes arbitrary values.
  function automatic int pick(int own, int other);
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return own;
    if (r < 6) return (own + 1) % M;
    if (r < 8) return other;
    return $urandom_range(0, M - 1);
  endfunction

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    model_reset();

    do_reset("reset");
    do_reset("reset");
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 5, 3, "idle");

    // Basic track/diverge sequence
    sample(0, 0, "seq0"); sample(1, 0, "seq1");
    sample(1, 1, "seq2"); sample(2, 1, "seq3");

    // x wraps 7 -> 0 while y > x
    do_reset("rst_wrap");
    sample(7, 7, "wrap0"); sample(0, 7, "wrap1");

    // Illegal x jump
    do_reset("rst_step");
    sample(3, 3, "step0"); sample(6, 3, "step1"); sample(6, 3, "step2");

    // Copy-back of x into y
    do_reset("rst_copy");
    sample(5, 2, "copy0"); sample(5, 5, "copy1");

    // Reset wins over a valid sample
    sample(6, 5, "pre_rst");
    drive(1'b1, 1'b1, 1, 7, "rst_valid");
    drive(1'b0, 1'b0, 1, 7, "post_rst");

    // sample_cnt saturation, idle cycles interleaved
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      sample(2, 2, "sat");
      if (i % 4 == 3) drive(1'b0, 1'b0, 4, 6, "sat_idle");
    end

    // Randomised segments
    for (int s = 0; s < 40; s++) begin
      int len;
      do_reset("rnd_rst");
      len = $urandom_range(5, 30);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          drive(1'b0, 1'b0, $urandom_range(0, M - 1), $urandom_range(0, M - 1), "rnd_idle");
        end else if (m_hp == 0) begin
          int v;
          v = $urandom_range(0, M - 1);
          sample(v, ($urandom_range(0, 1) != 0) ? v : $urandom_range(0, v), "rnd");
        end else begin
          sample(pick(m_px, m_py), pick(m_py, m_px), "rnd");
        end
      end
    end

    drive(1'b0, 1'b0, 0, 0, "tail");
    repeat (3) @(posedge clk);
    #3;
    chk("end", "scoreboard_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
